gate_selftest_checker: RTL and testbench
========================================

// Module: gate_selftest_checker
// PURPOSE
//  Synthesizable on-chip self-test for the basic gate cells (NAND2, OR2, NOT1, EXOR2, AND2).
//  Drives the shared a/b operands through all four input vectors and samples the five gate
//  outputs after a settle delay. Compares each output against a golden truth table and
//  reports pass/fail, error count and fault location.
//  Sits beside the ALU gate layer; a top-level controller or a bench pulses start and reads results.
// PARAMETERS
//  SETTLE_CYCLES  2   cycles waited after driving a vector before sampling (>=0)
//  ERR_W          4   width of err_count; the count saturates at 2**ERR_W-1
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  start      in   1      begin a test run; sampled only in IDLE or DONE
//  a_out      out  1      operand a to every gate under test
//  b_out      out  1      operand b to every gate under test
//  gate_in    in   5      gate results: [0]=nand [1]=or [2]=not(a) [3]=exor [4]=and
//  busy       out  1      high while a run is in progress
//  done       out  1      level; high from end of run until next start or reset
//  pass       out  1      valid when done: 1 = zero mismatches
//  err_count  out  ERR_W  number of mismatching gate bits, saturating
//  fail_mask  out  5      sticky OR of mismatching gate_in bits
//  fail_vec   out  2      index of first failing vector; 0 if none
// BEHAVIOUR
//  Reset values (async, immediate): state=IDLE; a_out=b_out=0; busy=done=pass=0;
//   err_count=0; fail_mask=0; fail_vec=0. Reset mid-run aborts the run; no partial result is kept.
//  Vector order: idx0 (a,b)=(0,0), idx1 (1,0), idx2 (0,1), idx3 (1,1). a_out=idx[0], b_out=idx[1].
//  Golden model: nand=~(a&b), or=a|b, not=~a, exor=a^b, and=a&b.
//  FSM: IDLE -> DRIVE -> SETTLE (SETTLE_CYCLES cycles, skipped if 0) -> SAMPLE
//   -> (idx<3 ? DRIVE with idx+1 : DONE).
//   DONE returns to DRIVE (idx0) on start.
//  DRIVE: a_out/b_out are updated for idx. They stay stable through SETTLE and SAMPLE.
//  SAMPLE: mismatch = gate_in ^ expect(idx).
//   err_count += popcount(mismatch), saturating at max.
//   fail_mask |= mismatch.
//   On the first nonzero mismatch of the run, fail_vec = idx.
//  Latency: start high at edge N gives busy=1 and DRIVE idx0 from edge N.
//   Each vector takes SETTLE_CYCLES+2 cycles.
//   done=1 and busy=0 from edge N+4*(SETTLE_CYCLES+2); e.g. N+16 when SETTLE_CYCLES=2.
//  pass = (err_count==0) && (fail_mask==0). It is registered together with done.
//  Restart from DONE: done, pass, err_count, fail_mask and fail_vec clear at the same edge that enters DRIVE.
//  start while busy: ignored, no effect on the run.
//  start held high continuously: a new run starts at the edge after each DONE.
//  a_out/b_out hold the idx3 values (1,1) in DONE and return to 0 only in IDLE (after reset).
//  gate_in is treated as synchronous to clk; no synchronizer inside.
// STRUCTURE
//  Package gate_test_pkg holds:
//   - state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE)
//   - gate bit-index constants (G_NAND=0 .. G_AND=4)
//   - the vector-to-(a,b) mapping constants
//  One sub-module, gate_expect: a combinational golden model mapping (a,b) -> 5-bit expected vector.
//  Top module holds the FSM, settle counter, vector index and result registers.
// TESTING
//  1 Real gate cells connected, SETTLE_CYCLES=2, start pulse at edge 0
//    -> done=1 at edge 16, pass=1, err_count=0, fail_mask=0, fail_vec=0.
//  2 not output stuck at 0 -> err_count=2, fail_mask=5'b00100, fail_vec=0, pass=0.
//  3 or/and outputs swapped -> err_count=4, fail_mask=5'b10010, fail_vec=1, pass=0.
//  4 all gate_in inverted (20 mismatches), ERR_W=4 -> err_count=15 (saturated), fail_mask=5'b11111, fail_vec=0.
//  5 rst at edge 7 mid-run -> all outputs at reset values immediately;
//    a following start runs a clean full sequence with correct results.
//  6 start pulsed at edge 5 while busy -> ignored, done still at edge 16.
//    Second start in DONE -> results clear at that edge and the run repeats identically.

Source files
------------

// File: rtl/gate_selftest_checker_pkg.sv
// Shared types and constants for the gate self-test checker: FSM states,
// gate bit positions in gate_in and the vector-index to (a,b) mapping.
package gate_test_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Bit positions of each gate result within gate_in / expected vector
  localparam int G_NAND  = 0;
  localparam int G_OR    = 1;
  localparam int G_NOT   = 2;
  localparam int G_EXOR  = 3;
  localparam int G_AND   = 4;
  localparam int N_GATES = 5;

  // Vector index -> operand values; bit i is the value for index i.
  // idx0 (0,0), idx1 (1,0), idx2 (0,1), idx3 (1,1)
  localparam int         N_VEC = 4;
  localparam logic [3:0] VEC_A = 4'b1010;
  localparam logic [3:0] VEC_B = 4'b1100;

  // Number of set bits in a 5-bit mismatch word
  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] sum;
    sum = 3'd0;
    for (int i = 0; i < 5; i++) begin
      sum = sum + 3'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/gate_selftest_checker_if.sv
// Bus between the self-test checker and whoever controls it / owns the
// gates under test.
//
// Handshake: start is a request sampled on the rising edge only while the
// checker is in IDLE or DONE; it is ignored while busy. busy is high for the
// whole run. done is a level that rises together with busy falling and stays
// high (with pass/err_count/fail_mask/fail_vec valid) until the next accepted
// start or reset. a_out/b_out drive the gates; gate_in returns their results
// synchronously to clk.
interface gate_selftest_checker_if #(
  parameter int ERR_W = 4
);
  import gate_test_pkg::*;

  logic             start;
  logic             a_out;
  logic             b_out;
  logic [4:0]       gate_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [4:0]       fail_mask;
  logic [1:0]       fail_vec;
  state_t           state_dbg;

  // Controller / gate-owner side
  modport master (
    output start, gate_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_mask, fail_vec,
           state_dbg
  );

  // Checker side
  modport slave (
    input  start, gate_in,
    output a_out, b_out, busy, done, pass, err_count, fail_mask, fail_vec,
           state_dbg
  );

endinterface

// File: rtl/gate_selftest_checker_expect.sv
// Golden truth table for the gate cells: operands (a,b) to the 5-bit vector
// the gates should return on gate_in.
module gate_expect
  import gate_test_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [4:0] exp_vec
);

  // Reference gate behaviour, one bit per gate position
  always_comb begin
    exp_vec         = '0;
    exp_vec[G_NAND] = ~(a & b);
    exp_vec[G_OR]   = a | b;
    exp_vec[G_NOT]  = ~a;
    exp_vec[G_EXOR] = a ^ b;
    exp_vec[G_AND]  = a & b;
  end

endmodule

// File: rtl/gate_selftest_checker.sv
// Gate self-test sequencer: walks the four operand vectors, waits for the
// gates to settle, compares gate_in against the golden table and accumulates
// error count, sticky failure mask and first failing vector.
module gate_selftest_checker
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input logic                   clk,
  input logic                   rst,
  gate_selftest_checker_if.slave bus
);

  localparam int               CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int               SUM_W   = ERR_W + 3;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [4:0]       mask_q, mask_d;
  logic [1:0]       vec_q, vec_d;

  logic [4:0]       exp_vec;
  logic [4:0]       mismatch;
  logic [SUM_W-1:0] err_sum;
  logic [ERR_W-1:0] err_sat;

  // Expected gate outputs for the operands currently on the bus
  gate_expect u_expect (
    .a       (a_q),
    .b       (b_q),
    .exp_vec (exp_vec)
  );

  // Mismatch and saturating error accumulation for the vector being sampled
  always_comb begin
    mismatch = bus.gate_in ^ exp_vec;
    err_sum  = SUM_W'(err_q) + SUM_W'(popcount5(mismatch));
    err_sat  = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];
  end

  // Next-state and next-result logic for the run sequencer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    mask_d  = mask_q;
    vec_d   = vec_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE, DONE: begin
        // A new run wipes the previous result on the same edge it starts
        if (bus.start) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          a_d     = VEC_A[0];
          b_d     = VEC_B[0];
          err_d   = '0;
          mask_d  = '0;
          vec_d   = '0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        cnt_d   = '0;
        state_d = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        if (int'(cnt_q) >= SETTLE_CYCLES - 1) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        err_d  = err_sat;
        mask_d = mask_q | mismatch;
        // An empty sticky mask means no vector has failed yet this run
        if ((mask_q == 5'd0) && (mismatch != 5'd0)) begin
          vec_d = idx_q;
        end
        if (idx_q == 2'(N_VEC - 1)) begin
          state_d = DONE;
          pass_d  = (err_d == '0) && (mask_d == 5'd0);
        end else begin
          state_d = DRIVE;
          idx_d   = idx_q + 2'd1;
          a_d     = VEC_A[idx_d];
          b_d     = VEC_B[idx_d];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; reset aborts any run in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      vec_q   <= vec_d;
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = mask_q;
  assign bus.fail_vec  = vec_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_gate_selftest_checker.sv
// Bench for gate_selftest_checker: models the gate cells with selectable
// faults, runs a table of full self-test runs with hand-computed results,
// then covers mid-run reset, start while busy and start held high.
module tb_gate_selftest_checker;
  import gate_test_pkg::*;

  localparam int RUN_LAT = 16;  // 4 vectors * (SETTLE_CYCLES + 2)

  logic clk;
  logic rst;
  int   fault;
  int   checks;
  int   failures;

  gate_selftest_checker_if #(.ERR_W(4)) gif ();

  gate_selftest_checker #(
    .SETTLE_CYCLES (2),
    .ERR_W         (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (gif.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- gate cells under test ----------------
  // 0 good, 1 not stuck at 0, 2 or/and swapped, 3 every output inverted
  logic [4:0] good;
  always_comb begin
    good[0] = ~(gif.a_out & gif.b_out);
    good[1] = gif.a_out | gif.b_out;
    good[2] = ~gif.a_out;
    good[3] = gif.a_out ^ gif.b_out;
    good[4] = gif.a_out & gif.b_out;
    case (fault)
      1:       gif.gate_in = good & 5'b11011;
      2:       gif.gate_in = {good[1], good[3], good[2], good[4], good[0]};
      3:       gif.gate_in = ~good;
      default: gif.gate_in = good;
    endcase
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    string      name;
    int         fault;
    logic [3:0] err;
    logic [4:0] mask;
    logic [1:0] vec;
    logic       pass;
  } run_vec_t;

  run_vec_t tbl[4];

  // Pulse start for one edge (edge N), then check the results were cleared
  // and busy is up; wait for done and return its latency in edges (0 = timeout).
  // inject_at > 0 raises start so it is sampled at edge N+inject_at.
  task automatic start_and_wait(input int inject_at, output int lat);
    gif.start = 1'b1;
    @(posedge clk);
    #1 gif.start = 1'b0;
    check("busy_after_start", gif.busy, 1'b1);
    check("done_cleared", gif.done, 1'b0);
    check("err_cleared", gif.err_count, 4'd0);
    check("mask_cleared", gif.fail_mask, 5'd0);
    check("vec_cleared", gif.fail_vec, 2'd0);
    check("pass_cleared", gif.pass, 1'b0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (gif.done) begin
        lat = k;
        break;
      end
      if (inject_at > 0 && k == inject_at - 1) gif.start = 1'b1;
      if (inject_at > 0 && k == inject_at) gif.start = 1'b0;
    end
  endtask

  task automatic check_result(input run_vec_t v, input int lat);
    check({v.name, "_latency"}, lat, RUN_LAT);
    check({v.name, "_busy"}, gif.busy, 1'b0);
    check({v.name, "_pass"}, gif.pass, v.pass);
    check({v.name, "_err"}, gif.err_count, v.err);
    check({v.name, "_mask"}, gif.fail_mask, v.mask);
    check({v.name, "_vec"}, gif.fail_vec, v.vec);
    check({v.name, "_ab"}, {gif.a_out, gif.b_out}, 2'b11);
    check({v.name, "_state"}, gif.state_dbg, DONE);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_state"}, gif.state_dbg, IDLE);
    check({name, "_ab"}, {gif.a_out, gif.b_out}, 2'b00);
    check({name, "_flags"}, {gif.busy, gif.done, gif.pass}, 3'b000);
    check({name, "_err"}, gif.err_count, 4'd0);
    check({name, "_mask"}, gif.fail_mask, 5'd0);
    check({name, "_vec"}, gif.fail_vec, 2'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    checks    = 0;
    failures  = 0;
    fault     = 0;
    gif.start = 1'b0;
    rst       = 1'b1;

    tbl[0] = '{name: "good",      fault: 0, err: 4'd0,  mask: 5'b00000, vec: 2'd0, pass: 1'b1};
    tbl[1] = '{name: "not_sa0",   fault: 1, err: 4'd2,  mask: 5'b00100, vec: 2'd0, pass: 1'b0};
    tbl[2] = '{name: "or_and_sw", fault: 2, err: 4'd4,  mask: 5'b10010, vec: 2'd1, pass: 1'b0};
    tbl[3] = '{name: "all_inv",   fault: 3, err: 4'd15, mask: 5'b11111, vec: 2'd0, pass: 1'b0};

    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table of full runs, each restarted from DONE of the previous one
    for (int i = 0; i < 4; i++) begin
      fault = tbl[i].fault;
      start_and_wait(0, lat);
      check_result(tbl[i], lat);
      @(posedge clk);
      #1 check({tbl[i].name, "_done_hold"}, gif.done, 1'b1);
    end

    // Reset seven edges into a failing run: everything returns to reset values
    fault = 3;
    gif.start = 1'b1;
    @(posedge clk);
    #1 gif.start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("midrun_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check_reset_values("after_rst");

    // Clean run after the abort
    fault = 0;
    start_and_wait(0, lat);
    check_result(tbl[0], lat);

    // start sampled at edge N+5 while busy is ignored; rerun repeats identically
    fault = 2;
    start_and_wait(5, lat);
    check_result(tbl[2], lat);
    start_and_wait(0, lat);
    check_result(tbl[2], lat);

    // start held high: a new run begins on the edge after DONE
    fault = 0;
    @(posedge clk);
    #1 gif.start = 1'b1;
    @(posedge clk);
    #1 lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (gif.done) begin
        lat = k;
        break;
      end
    end
    check("held_latency", lat, RUN_LAT);
    check("held_pass", gif.pass, 1'b1);
    @(posedge clk);
    #1 check("held_restart", {gif.busy, gif.done}, 2'b10);
    gif.start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
